cacheline_adaptor: RTL and testbench

Responder for the 256-bit `pmem_*` line interface driven by the cache hierarchy's arbiter. It converts each single-cycle line request into a multi-beat burst on a narrow DRAM-side port, then returns one `pmem_resp` pulse. It sits between the cache top and physical memory, so the caches stay unaware of burst width.

---
 rtl/cacheline_adaptor.sv | 121 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit line request to narrow DRAM burst adaptor.
// Optional macro CACHELINE_ADAPTOR_FWD_EN: forward the final read beat and respond in that same cycle.
module cacheline_adaptor #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pmem_read,
    input  logic                      pmem_write,
    input  logic [31:0]               pmem_address,
    input  logic [BEATS*BEAT_W-1:0]   pmem_wdata,
    output logic [BEATS*BEAT_W-1:0]   pmem_rdata,
    output logic                      pmem_resp,
    output logic                      dram_read,
    output logic                      dram_write,
    output logic [31:0]               dram_address,
    output logic [BEAT_W-1:0]         dram_wdata,
    input  logic [BEAT_W-1:0]         dram_rdata,
    input  logic                      dram_resp
);

    localparam int LINE_W = BEATS * BEAT_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   wbuf_q, wbuf_d;
    logic [LINE_W-1:0]   rbuf_q, rbuf_d;
    logic                last_beat;
    logic                addr_unused;

    // Byte offset within the line is meaningless on the burst side.
    assign addr_unused = ^pmem_address[OFF_W-1:0];
    assign last_beat   = dram_resp && (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    addr_d  = {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
                    wbuf_d  = pmem_wdata;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (pmem_read) begin
                    addr_d  = {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (dram_resp) begin
                    rbuf_d[cnt_q*BEAT_W +: BEAT_W] = dram_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
`ifdef CACHELINE_ADAPTOR_FWD_EN
                        state_d = IDLE;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            WRITE: begin
                if (dram_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assign dram_read    = (state_q == READ);
    assign dram_write   = (state_q == WRITE);
    assign dram_address = addr_q;
    assign dram_wdata   = dram_write ? wbuf_q[cnt_q*BEAT_W +: BEAT_W] : '0;

`ifdef CACHELINE_ADAPTOR_FWD_EN
    logic fwd;
    assign fwd        = (state_q == READ) && last_beat;
    assign pmem_resp  = (state_q == DONE) || fwd;
    assign pmem_rdata = fwd ? {dram_rdata, rbuf_q[(BEATS-1)*BEAT_W-1:0]} : rbuf_q;
`else
    assign pmem_resp  = (state_q == DONE);
    assign pmem_rdata = rbuf_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor.
module tb_cacheline_adaptor;

`ifdef CACHELINE_ADAPTOR_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic         dram_read, dram_write;
    logic [31:0]  dram_address;
    logic [63:0]  dram_wdata, dram_rdata;
    logic         dram_resp;

    int checks   = 0;
    int failures = 0;

    logic [255:0] l1, lw, lg, lw2, l5;
    int           r_cnt, r_cyc, rd_hi, wr_hi, extra;

    always #5 clk = ~clk;

    cacheline_adaptor #(.BEATS(4), .BEAT_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .dram_read    (dram_read),
        .dram_write   (dram_write),
        .dram_address (dram_address),
        .dram_wdata   (dram_wdata),
        .dram_rdata   (dram_rdata),
        .dram_resp    (dram_resp)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, output int resp_seen);
        resp_seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            dram_resp = 1'b0;
            #1;
            if (pmem_resp) resp_seen++;
        end
    endtask

    // Drives one line request and plays the DRAM side; gap = idle cycles between beats.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] line, input int gap, input logic keep_rd,
                           output int resp_cnt, output int resp_cyc,
                           output int rhi, output int whi);
        int  beat;
        int  gapc;
        bit  done;
        resp_cnt = 0; resp_cyc = 0; rhi = 0; whi = 0;
        beat = 0; gapc = gap; done = 1'b0;
        pmem_address = addr;
        pmem_read    = rd;
        pmem_write   = wr;
        if (wr) pmem_wdata = line;
        for (int c = 1; c <= 60 && !done; c++) begin
            step();
            dram_resp = 1'b0;
            if ((wr ? dram_write : dram_read) && beat < 4 && gapc >= gap) begin
                chk("dram_address", 256'(dram_address), 256'({addr[31:5], 5'b0}));
                if (wr) chk($sformatf("wdata_beat%0d", beat), 256'(dram_wdata), 256'(line[beat*64 +: 64]));
                else dram_rdata = line[beat*64 +: 64];
                dram_resp = 1'b1;
                beat++;
                gapc = 0;
            end else begin
                gapc++;
            end
            #1;
            if (dram_read)  rhi++;
            if (dram_write) whi++;
            if (pmem_resp) begin
                resp_cnt++;
                resp_cyc = c;
                if (!wr) chk("read_line", pmem_rdata, line);
                pmem_write = 1'b0;
                if (!keep_rd) pmem_read = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) chk("resp_timeout", 256'(done), 256'(1));
    endtask

    initial begin
        rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
        pmem_wdata = '0; dram_rdata = '0; dram_resp = 1'b0;
        l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lw  = {64'hDEAD_0000_5555_AAAA, 64'hCAFE_F00D_1234_5678,
               64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_BEEF};
        lg  = {64'h3C3C_3C3C_3C3C_3C3C, 64'hC3C3_C3C3_C3C3_C3C3,
               64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5};
        lw2 = {64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002,
               64'h8000_0000_0000_0003, 64'hF0F0_0F0F_F0F0_0F0F};
        l5  = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
               64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_pmem_rdata", pmem_rdata, '0);
        chk("rst_pmem_resp", 256'(pmem_resp), 256'(0));
        chk("rst_dram_read", 256'(dram_read), 256'(0));
        chk("rst_dram_write", 256'(dram_write), 256'(0));
        chk("rst_dram_address", 256'(dram_address), 256'(0));
        chk("rst_dram_wdata", 256'(dram_wdata), 256'(0));

        // Stray beat strobe with no request pending
        step();
        dram_resp = 1'b1;
        dram_rdata = '1;
        #1;
        chk("idle_strobe_resp", 256'(pmem_resp), 256'(0));
        chk("idle_strobe_dram_read", 256'(dram_read), 256'(0));
        step();
        dram_resp = 1'b0;
        #1;
        chk("idle_strobe_rdata", pmem_rdata, '0);
        chk("idle_strobe_dram_rw", 256'({dram_read, dram_write}), 256'(0));

        run_req(1'b1, 1'b0, 32'h0000_1234, l1, 0, 1'b0, r_cnt, r_cyc, rd_hi, wr_hi);
        chk("rd1_resp_cnt", 256'(r_cnt), 256'(1));
        chk("rd1_resp_cycle", 256'(r_cyc), 256'(5 - FWD));
        chk("rd1_dram_read_cycles", 256'(rd_hi), 256'(4));
        chk("rd1_dram_write_cycles", 256'(wr_hi), 256'(0));
        idle_cycles(3, extra);
        chk("rd1_extra_resp", 256'(extra), 256'(0));
        chk("rd1_rdata_hold", pmem_rdata, l1);

        run_req(1'b0, 1'b1, 32'h0000_2000, lw, 0, 1'b0, r_cnt, r_cyc, rd_hi, wr_hi);
        chk("wr_resp_cnt", 256'(r_cnt), 256'(1));
        chk("wr_resp_cycle", 256'(r_cyc), 256'(5));
        chk("wr_dram_write_cycles", 256'(wr_hi), 256'(4));
        chk("wr_dram_read_cycles", 256'(rd_hi), 256'(0));
        idle_cycles(3, extra);
        chk("wr_extra_resp", 256'(extra), 256'(0));
        chk("wr_rdata_untouched", pmem_rdata, l1);

        run_req(1'b1, 1'b0, 32'h0000_ABCF, lg, 2, 1'b0, r_cnt, r_cyc, rd_hi, wr_hi);
        chk("gap_resp_cnt", 256'(r_cnt), 256'(1));
        chk("gap_resp_cycle", 256'(r_cyc), 256'(11 - FWD));
        chk("gap_dram_read_cycles", 256'(rd_hi), 256'(10));
        idle_cycles(3, extra);
        chk("gap_extra_resp", 256'(extra), 256'(0));

        run_req(1'b1, 1'b1, 32'h8000_0047, lw2, 0, 1'b1, r_cnt, r_cyc, rd_hi, wr_hi);
        chk("both_resp_cnt", 256'(r_cnt), 256'(1));
        chk("both_dram_write_cycles", 256'(wr_hi), 256'(4));
        chk("both_dram_read_cycles", 256'(rd_hi), 256'(0));
        chk("both_rdata_untouched", pmem_rdata, lg);
        run_req(1'b1, 1'b0, 32'h8000_0047, lw2, 0, 1'b0, r_cnt, r_cyc, rd_hi, wr_hi);
        chk("both_follow_resp_cnt", 256'(r_cnt), 256'(1));
        chk("both_follow_resp_cycle", 256'(r_cyc), 256'(6 - FWD));
        chk("both_follow_dram_write", 256'(wr_hi), 256'(0));
        idle_cycles(2, extra);
        chk("both_extra_resp", 256'(extra), 256'(0));

        // Reset after two beats of a read
        pmem_address = 32'h0000_0F00;
        pmem_read = 1'b1;
        step();
        dram_rdata = l5[63:0];
        dram_resp = 1'b1;
        step();
        dram_rdata = l5[127:64];
        step();
        dram_resp = 1'b0;
        rst = 1'b1;
        pmem_read = 1'b0;
        step();
        rst = 1'b0;
        dram_resp = 1'b1;
        dram_rdata = l5[191:128];
        #1;
        chk("midrst_pmem_rdata", pmem_rdata, '0);
        chk("midrst_pmem_resp", 256'(pmem_resp), 256'(0));
        chk("midrst_dram_rw", 256'({dram_read, dram_write}), 256'(0));
        chk("midrst_dram_address", 256'(dram_address), 256'(0));
        chk("midrst_dram_wdata", 256'(dram_wdata), 256'(0));
        step();
        dram_resp = 1'b1;
        dram_rdata = l5[255:192];
        #1;
        chk("stray_resp", 256'(pmem_resp), 256'(0));
        idle_cycles(3, extra);
        chk("stray_extra_resp", 256'(extra), 256'(0));
        run_req(1'b1, 1'b0, 32'h0000_0F00, l5, 0, 1'b0, r_cnt, r_cyc, rd_hi, wr_hi);
        chk("post_rst_resp_cnt", 256'(r_cnt), 256'(1));
        chk("post_rst_resp_cycle", 256'(r_cyc), 256'(5 - FWD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
